// File: rtl/clock_pkg.sv
// Shared limits, widths and mode encoding for the clock time-keeping
// and alarm datapaths.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MS_W   = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MS_W-1:0]   MIN_MAX  = 6'd59;
    localparam logic [MS_W-1:0]   SEC_MAX  = 6'd59;

    localparam int BLK_H = 2;
    localparam int BLK_M = 1;
    localparam int BLK_S = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            RUN:     return SET_H;
            SET_H:   return SET_M;
            SET_M:   return SET_S;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/hour_fmt.sv
// Combinational 24 h to 12 h display conversion, shared with the alarm path.
module hour_fmt
    import clock_pkg::*;
(
    input  logic [HOUR_W-1:0] hour,
    input  logic              fmt12,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              pm
);

    always_comb begin
        hour_disp = hour;
        pm        = (hour >= 5'd12);
        if (fmt12) begin
            if (hour == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour > 5'd12) begin
                hour_disp = hour - 5'd12;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-keeping registers, button-driven set-mode FSM and blink masking
// for the digital clock display.
module clock_set_ctrl
    import clock_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              tick_2hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_fmt,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] hour_disp,
    output logic [MS_W-1:0]   min,
    output logic [MS_W-1:0]   sec,
    output logic              pm,
    output logic              fmt12,
    output logic [1:0]        mode,
    output logic [2:0]        blank_mask
);

    mode_t             mode_q, mode_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MS_W-1:0]   min_q, min_d;
    logic [MS_W-1:0]   sec_q, sec_d;
    logic              fmt12_q, fmt12_d;
    logic              phase_q, phase_d;
    logic [2:0]        blank_q, blank_d;
    logic              inc_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= RUN;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            fmt12_q <= 1'b0;
            phase_q <= 1'b0;
            blank_q <= 3'b000;
        end else begin
            mode_q  <= mode_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            fmt12_q <= fmt12_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    // A mode press on the same edge as an inc swallows the inc.
    assign inc_evt = btn_inc & ~btn_mode;

    always_comb begin
        mode_d  = mode_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        fmt12_d = fmt12_q ^ btn_fmt;

        case (mode_q)
            RUN: begin
                if (tick_1hz) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        if (min_q == MIN_MAX) begin
                            min_d  = '0;
                            hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_H: begin
                if (inc_evt) begin
                    hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                end
            end
            SET_M: begin
                if (inc_evt) begin
                    min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                end
            end
            default: begin
                if (inc_evt) begin
                    sec_d = '0;
                end
            end
        endcase

        if (btn_mode) begin
            mode_d = next_mode(mode_q);
        end
    end

    // Entering a set state or adjusting a field restarts blink visible.
    always_comb begin
        phase_d = phase_q;
        blank_d = 3'b000;

        if (mode_d == RUN || btn_mode || btn_inc) begin
            phase_d = 1'b0;
        end else if (tick_2hz) begin
            phase_d = ~phase_q;
        end

        case (mode_d)
            SET_H:   blank_d[BLK_H] = phase_d;
            SET_M:   blank_d[BLK_M] = phase_d;
            SET_S:   blank_d[BLK_S] = phase_d;
            default: blank_d = 3'b000;
        endcase
    end

    hour_fmt u_hour_fmt (
        .hour      (hour_q),
        .fmt12     (fmt12_q),
        .hour_disp (hour_disp),
        .pm        (pm)
    );

    assign hour       = hour_q;
    assign min        = min_q;
    assign sec        = sec_q;
    assign fmt12      = fmt12_q;
    assign mode       = mode_q;
    assign blank_mask = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench: seconds-of-day model compared every cycle, plus
// directed literal expectations that pin the model.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_fmt = 1'b0;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic       fmt12;
    logic [1:0] mode;
    logic [2:0] blank_mask;

    int checks = 0;
    int fails = 0;

    // Model state: time as seconds since midnight, mode as 0..3.
    int   m_tod = 0;
    int   m_mode = 0;
    logic m_phase = 1'b0;
    logic m_fmt = 1'b0;
    logic m_valid = 1'b0;

    clock_set_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_fmt    (btn_fmt),
        .hour       (hour),
        .hour_disp  (hour_disp),
        .min        (min),
        .sec        (sec),
        .pm         (pm),
        .fmt12      (fmt12),
        .mode       (mode),
        .blank_mask (blank_mask)
    );

    always #5 clk = ~clk;

    // Reference model advanced on every rising edge.
    always @(posedge clk) begin
        int h, m, s, nmode;
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        s = m_tod % 60;
        if (rst) begin
            m_tod = 0; m_mode = 0; m_phase = 1'b0; m_fmt = 1'b0; m_valid = 1'b1;
        end else begin
            if (m_mode == 0 && tick_1hz) m_tod = (m_tod + 1) % 86400;
            if (m_mode != 0 && btn_inc && !btn_mode) begin
                if (m_mode == 1) h = (h + 1) % 24;
                if (m_mode == 2) m = (m + 1) % 60;
                if (m_mode == 3) s = 0;
                m_tod = h * 3600 + m * 60 + s;
            end
            nmode = btn_mode ? (m_mode + 1) % 4 : m_mode;
            if (tick_2hz) m_phase = ~m_phase;
            if (nmode == 0 || btn_mode || btn_inc) m_phase = 1'b0;
            m_mode = nmode;
            if (btn_fmt) m_fmt = ~m_fmt;
        end
    end

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int h, e_disp, e_mask;
        h = m_tod / 3600;
        e_disp = m_fmt ? ((h % 12 == 0) ? 12 : h % 12) : h;
        e_mask = (m_mode == 0) ? 0 : (int'(m_phase) << (3 - m_mode));
        checkField("hour", int'(hour), h);
        checkField("min", int'(min), (m_tod / 60) % 60);
        checkField("sec", int'(sec), m_tod % 60);
        checkField("hour_disp", int'(hour_disp), e_disp);
        checkField("pm", int'(pm), (h >= 12) ? 1 : 0);
        checkField("fmt12", int'(fmt12), int'(m_fmt));
        checkField("mode", int'(mode), m_mode);
        checkField("blank_mask", int'(blank_mask), e_mask);
    endtask

    always @(negedge clk) begin
        if (m_valid) checkOutput();
    end

    // One clock cycle of stimulus: drive on falling edge, hold through rising edge.
    task automatic applyStimulus(input logic r, input logic t1, input logic t2,
                                 input logic bm, input logic bi, input logic bf);
        @(negedge clk);
        rst = r; tick_1hz = t1; tick_2hz = t2;
        btn_mode = bm; btn_inc = bi; btn_fmt = bf;
        @(posedge clk);
        #1;
        rst = 0; tick_1hz = 0; tick_2hz = 0;
        btn_mode = 0; btn_inc = 0; btn_fmt = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    endtask

    task automatic modePress();
        applyStimulus(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 1);
        checkField("lit_reset_hour", int'(hour), 0);
        checkField("lit_reset_mode", int'(mode), 0);
        checkField("lit_reset_mask", int'(blank_mask), 0);
        checkField("lit_reset_fmt", int'(fmt12), 0);

        ticks(3661);
        checkField("lit_3661_hour", int'(hour), 1);
        checkField("lit_3661_min", int'(min), 1);
        checkField("lit_3661_sec", int'(sec), 1);

        applyStimulus(1, 0, 0, 0, 0, 0);
        ticks(59);
        modePress(); incs(23); modePress(); incs(59); modePress(); modePress();
        checkField("lit_pre_hour", int'(hour), 23);
        checkField("lit_pre_min", int'(min), 59);
        checkField("lit_pre_sec", int'(sec), 59);
        ticks(1);
        checkField("lit_wrap_hour", int'(hour), 0);
        checkField("lit_wrap_sec", int'(sec), 0);

        modePress(); incs(10); modePress(); incs(20); modePress(); modePress();
        ticks(30);
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkField("lit_tickmode_sec", int'(sec), 31);
        checkField("lit_tickmode_mode", int'(mode), 1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            applyStimulus(0, 1, 0, 0, 0, 0);
        end
        checkField("lit_seth_hour", int'(hour), 1);
        checkField("lit_seth_min", int'(min), 20);
        checkField("lit_seth_sec", int'(sec), 31);

        modePress(); incs(39);
        checkField("lit_setm_min59", int'(min), 59);
        incs(1);
        checkField("lit_setm_wrap", int'(min), 0);
        checkField("lit_setm_hour", int'(hour), 1);
        modePress(); incs(1);
        checkField("lit_sets_sec", int'(sec), 0);
        modePress(); ticks(1);
        checkField("lit_run_sec", int'(sec), 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkField("lit_run_mask", int'(blank_mask), 0);

        applyStimulus(0, 0, 0, 0, 0, 1);
        checkField("lit_fmt_on", int'(fmt12), 1);
        modePress(); incs(23);
        checkField("lit_disp_h0", int'(hour_disp), 12);
        checkField("lit_pm_h0", int'(pm), 0);
        incs(11);
        checkField("lit_disp_h11", int'(hour_disp), 11);
        incs(1);
        checkField("lit_disp_h12", int'(hour_disp), 12);
        checkField("lit_pm_h12", int'(pm), 1);
        incs(1);
        checkField("lit_disp_h13", int'(hour_disp), 1);
        incs(10);
        checkField("lit_disp_h23", int'(hour_disp), 11);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkField("lit_disp_24h", int'(hour_disp), 23);

        checkField("lit_blink0", int'(blank_mask), 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkField("lit_blink1", int'(blank_mask), 4);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkField("lit_blink2", int'(blank_mask), 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkField("lit_blink3", int'(blank_mask), 4);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkField("lit_blink4", int'(blank_mask), 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        incs(1);
        checkField("lit_blink_inc", int'(blank_mask), 0);

        applyStimulus(0, 0, 0, 1, 1, 0);
        checkField("lit_modeinc_mode", int'(mode), 2);
        checkField("lit_modeinc_hour", int'(hour), 0);
        incs(33);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkField("lit_blink_m", int'(blank_mask), 2);
        applyStimulus(1, 1, 1, 0, 1, 0);
        checkField("lit_rst_min", int'(min), 0);
        checkField("lit_rst_mode", int'(mode), 0);
        checkField("lit_rst_mask", int'(blank_mask), 0);
        checkField("lit_rst_fmt", int'(fmt12), 0);
        ticks(2);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
